// File: rtl/uart_digit_scan.sv
// Buffers up to four UART decimal digits and time-multiplexes them onto a 4-digit common-anode display.
// Byte to display takes 2 edges, and an unsupported byte flags oErr one edge after it is absorbed; every strobe is accepted, with no backpressure.
module uart_digit_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iRxData,
  input  logic       iRxValid,
  output logic [3:0] oDigit,
  output logic [3:0] oAnode,
  output logic       oErr
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [3:0]       slot_vld_q, slot_vld_d;
  logic [3:0][3:0]  slot_val_q, slot_val_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       anode_q, anode_d;
  logic [3:0]       digit_q, digit_d;
  logic             bad_q, bad_d;
  logic             err_q, err_d;

  logic is_digit, is_bs, is_esc, scan_term;

  assign is_digit  = (iRxData >= 8'h30) && (iRxData <= 8'h39);
  assign is_bs     = (iRxData == 8'h08);
  assign is_esc    = (iRxData == 8'h1B);
  assign scan_term = (cnt_q == CNT_LAST);

  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_val_d = slot_val_q;
    bad_d      = 1'b0;
    if (iRxValid) begin
      if (is_digit) begin
        // ASCII '0'..'9' carry their value in the low nibble.
        slot_vld_d = {slot_vld_q[2:0], 1'b1};
        slot_val_d = {slot_val_q[2:0], iRxData[3:0]};
      end else if (is_bs) begin
        slot_vld_d = {1'b0, slot_vld_q[3:1]};
        slot_val_d = {4'h0, slot_val_q[3:1]};
      end else if (is_esc) begin
        slot_vld_d = 4'b0000;
      end else begin
        bad_d = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = scan_term ? '0 : cnt_q + 1'b1;
    idx_d = scan_term ? idx_q + 2'd1 : idx_q;
  end

  always_comb begin
    anode_d = 4'b1111;
    digit_d = 4'hF;
    if (slot_vld_q[idx_q]) begin
      anode_d = ~(4'b0001 << idx_q);
      digit_d = slot_val_q[idx_q];
    end
    err_d = bad_q;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      slot_vld_q <= 4'b0000;
      slot_val_q <= '0;
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      anode_q    <= 4'b1111;
      digit_q    <= 4'hF;
      bad_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_val_q <= slot_val_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      anode_q    <= anode_d;
      digit_q    <= digit_d;
      bad_q      <= bad_d;
      err_q      <= err_d;
    end
  end

  assign oDigit = digit_q;
  assign oAnode = anode_q;
  assign oErr   = err_q;

endmodule
